// File: rtl/scan_frame_ctrl_if.sv
// LLR stream and decoded-word handshake between the source/sink and the frame sequencer.
// The slave side is the sequencer; master is the environment feeding LLRs and taking words.
interface scan_frame_ctrl_if #(
  parameter int Q = 6
);
  logic [Q-1:0] llr_in;
  logic         llr_valid;
  logic         llr_ready;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output llr_in,
    output llr_valid,
    output out_ready,
    input  llr_ready,
    input  out_valid
  );

  modport slave (
    input  llr_in,
    input  llr_valid,
    input  out_ready,
    output llr_ready,
    output out_valid
  );
endinterface

// File: rtl/scan_frame_ctrl.sv
// Frame sequencer for the SCAN polar decoder core: clears the core, streams N LLRs in,
// settles, runs the decode window, then holds the decoded word until it is taken.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, core frozen
// S_CLEAR  | one-cycle synchronous reset of the core
// S_LOAD   | accepting LLRs; core enabled only the cycle after a transfer
// S_SETTLE | channel-buffer flush / program-counter preroll
// S_DECODE | core running with channel=1 for DEC_CYC cycles
// S_OUT    | decoded word held (core frozen) until out_ready
module scan_frame_ctrl #(
  parameter int N          = 1024,
  parameter int Q          = 6,
  parameter int SETTLE_CYC = 2,
  parameter int DEC_CYC    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  scan_frame_ctrl_if.slave      bus,
  output logic [Q-1:0]          dec_llr,
  output logic                  dec_channel,
  output logic                  dec_en,
  output logic                  dec_rst,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  drop_err
);

  localparam int LCW    = (N > 1) ? $clog2(N) : 1;
  localparam int PH_MAX = (DEC_CYC > SETTLE_CYC) ? DEC_CYC : SETTLE_CYC;
  localparam int PCW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [LCW-1:0] LOAD_LAST   = LCW'(N - 1);
  localparam logic [PCW-1:0] SETTLE_LAST = PCW'(SETTLE_CYC - 1);
  localparam logic [PCW-1:0] DEC_LAST    = PCW'(DEC_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_DECODE,
    S_OUT
  } state_t;

  state_t         state, state_nx;
  logic [LCW-1:0] load_cnt, load_cnt_nx;
  logic [PCW-1:0] phase_cnt, phase_cnt_nx;
  logic           xfer;
  logic           frame_done;
  logic           dec_en_nx, dec_channel_nx, dec_rst_nx, out_valid_nx, drop_err_nx;
  logic [15:0]    frame_q;

  assign bus.llr_ready = (state == S_LOAD);
  assign busy          = (state != S_IDLE);
  assign xfer          = (state == S_LOAD) && bus.llr_valid;
  assign frame_done    = (state == S_OUT) && bus.out_ready;
  assign frame_cnt     = frame_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      state     <= state_nx;
      load_cnt  <= load_cnt_nx;
      phase_cnt <= phase_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    load_cnt_nx  = load_cnt;
    phase_cnt_nx = phase_cnt;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        state_nx     = S_LOAD;
        load_cnt_nx  = '0;
        phase_cnt_nx = '0;
      end
      S_LOAD: begin
        if (xfer) begin
          if (load_cnt == LOAD_LAST) begin
            state_nx    = S_SETTLE;
            load_cnt_nx = '0;
          end else begin
            load_cnt_nx = load_cnt + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (phase_cnt == SETTLE_LAST) begin
          state_nx     = S_DECODE;
          phase_cnt_nx = '0;
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (phase_cnt == DEC_LAST) begin
          state_nx     = S_OUT;
          phase_cnt_nx = '0;
        end else begin
          phase_cnt_nx = phase_cnt + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Registered outputs describe the cycle being entered, so they decode state_nx.
    dec_en_nx      = (state_nx == S_CLEAR) || (state_nx == S_SETTLE) ||
                     (state_nx == S_DECODE) || xfer;
    dec_channel_nx = (state_nx == S_DECODE) || (state_nx == S_OUT);
    dec_rst_nx     = (state_nx == S_CLEAR);
    out_valid_nx   = (state_nx == S_OUT);

    if ((state == S_CLEAR) || (state_nx == S_CLEAR))
      drop_err_nx = 1'b0;
    else if ((state != S_IDLE) && bus.llr_valid && !bus.llr_ready)
      drop_err_nx = 1'b1;
    else
      drop_err_nx = drop_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_en        <= 1'b0;
      dec_channel   <= 1'b0;
      dec_rst       <= 1'b1;
      bus.out_valid <= 1'b0;
      drop_err      <= 1'b0;
      dec_llr       <= '0;
    end else begin
      dec_en        <= dec_en_nx;
      dec_channel   <= dec_channel_nx;
      dec_rst       <= dec_rst_nx;
      bus.out_valid <= out_valid_nx;
      drop_err      <= drop_err_nx;
      if (xfer) dec_llr <= bus.llr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            frame_q <= '0;
    else if (frame_done) frame_q <= frame_q + 16'd1;
  end

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Randomized bench for scan_frame_ctrl: each frame is scored cycle by cycle against a
// phase/timing model derived from accepted-sample counts and the fixed phase lengths.
module tb_scan_frame_ctrl;

  localparam int N = 8;
  localparam int Q = 6;
  localparam int S = 2;
  localparam int D = 20;

  localparam int P_IDLE   = 0;
  localparam int P_CLEAR  = 1;
  localparam int P_LOAD   = 2;
  localparam int P_SETTLE = 3;
  localparam int P_DECODE = 4;
  localparam int P_OUT    = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [Q-1:0]  dec_llr;
  logic          dec_channel, dec_en, dec_rst, busy, drop_err;
  logic [15:0]   frame_cnt;

  scan_frame_ctrl_if #(.Q(Q)) bus ();

  scan_frame_ctrl #(.N(N), .Q(Q), .SETTLE_CYC(S), .DEC_CYC(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .dec_llr     (dec_llr),
    .dec_channel (dec_channel),
    .dec_en      (dec_en),
    .dec_rst     (dec_rst),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .drop_err    (drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           n_cmp = 0;
  int           n_err = 0;
  int           cur_t = 0;
  logic [Q-1:0] exp_llr = '0;
  logic [15:0]  exp_frames = '0;
  logic         exp_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (t=%0d): got %0h expected %0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic int phase_of(int t, int last_acc, int hs);
    if (t == 0) return P_IDLE;
    if (t == 1) return P_CLEAR;
    if (last_acc < 0) return P_LOAD;
    if (t - last_acc <= S) return P_SETTLE;
    if (t - last_acc <= S + D) return P_DECODE;
    if (t <= hs) return P_OUT;
    return P_IDLE;
  endfunction

  // mode: 0 = llr_valid always 1, 1 = low every third cycle, 2 = random gaps.
  // flood: drive llr_valid outside LOAD too; spam: pulse start during DECODE/OUT.
  task automatic run_frame(input int mode, input int hold, input int flood, input int spam);
    int   t, ph, acc, last_acc, rise, hs, bubbles, en_cnt, rise_seen;
    logic v, prev_acc;
    t = 0; acc = 0; last_acc = -1; rise = -1; hs = -1;
    bubbles = 0; en_cnt = 0; rise_seen = -1; prev_acc = 1'b0;
    while (1) begin
      cur_t = t;
      ph = phase_of(t, last_acc, hs);
      start = (t == 0) ||
              ((spam != 0) && (ph == P_DECODE || ph == P_OUT) && ($urandom_range(0, 3) == 0));
      if (ph == P_LOAD)
        v = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 3) != 0) : ($urandom_range(0, 9) >= 3);
      else
        v = (flood == 0) ? 1'b0 : (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.llr_valid = v;
      bus.llr_in    = Q'($urandom);
      bus.out_ready = (ph == P_OUT) ? ((t - rise) >= hold) : 1'($urandom_range(0, 1));

      @(negedge clk);
      chk("busy",        busy,          ph != P_IDLE);
      chk("llr_ready",   bus.llr_ready, ph == P_LOAD);
      chk("dec_rst",     dec_rst,       ph == P_CLEAR);
      chk("dec_en",      dec_en,        (ph == P_CLEAR) || (ph == P_SETTLE) || (ph == P_DECODE) ||
                                        ((ph == P_LOAD) && prev_acc));
      chk("dec_channel", dec_channel,   (ph == P_DECODE) || (ph == P_OUT));
      chk("out_valid",   bus.out_valid, ph == P_OUT);
      chk("dec_llr",     dec_llr,       exp_llr);
      chk("frame_cnt",   frame_cnt,     exp_frames);
      chk("drop_err",    drop_err,      exp_drop);
      if (dec_en && !dec_rst && !dec_channel) en_cnt++;
      if (bus.out_valid && rise_seen < 0) rise_seen = t;

      prev_acc = 1'b0;
      if (ph == P_LOAD) begin
        if (v) begin
          exp_llr  = bus.llr_in;
          prev_acc = 1'b1;
          acc++;
          if (acc == N) begin
            last_acc = t;
            rise     = t + 1 + S + D;
            hs       = rise + hold;
          end
        end else begin
          bubbles++;
        end
      end
      if ((ph == P_SETTLE || ph == P_DECODE || ph == P_OUT) && v) exp_drop = 1'b1;
      if (t == 0) exp_drop = 1'b0;
      if (t == hs) exp_frames = exp_frames + 16'd1;
      if (hs >= 0 && t == hs + 1) break;
      if (t > 4000) begin
        chk("frame_timeout", t, 0);
        break;
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    bus.llr_valid = 1'b0;
    @(posedge clk); #1;
    chk("latency",        rise_seen, N + 2 + S + D + bubbles);
    chk("load_en_cycles", en_cnt,    N + S - 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.llr_valid = 1'b0;
    bus.llr_in    = '0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_dec_rst",     dec_rst,       1);
    chk("rst_dec_en",      dec_en,        0);
    chk("rst_dec_channel", dec_channel,   0);
    chk("rst_llr_ready",   bus.llr_ready, 0);
    chk("rst_out_valid",   bus.out_valid, 0);
    chk("rst_busy",        busy,          0);
    chk("rst_drop_err",    drop_err,      0);
    chk("rst_dec_llr",     dec_llr,       0);
    chk("rst_frame_cnt",   frame_cnt,     0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_dec_rst", dec_rst, 0);
    chk("rel_busy",    busy,    0);

    run_frame(0, 0, 1, 0);
    run_frame(1, 0, 0, 0);
    run_frame(2, 50, 0, 1);
    run_frame(2, 3, 1, 0);

    // Abort a frame mid-DECODE with an asynchronous reset between edges.
    start = 1'b1;
    bus.llr_valid = 1'b1;
    bus.llr_in = Q'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + S + 8) begin
      bus.llr_in = Q'($urandom);
      @(posedge clk); #1;
    end
    chk("pre_rst_channel", dec_channel, 1);
    chk("pre_rst_drop",    drop_err,    1);
    #3 rst = 1'b0;
    #1;
    chk("arst_dec_rst",     dec_rst,       1);
    chk("arst_dec_en",      dec_en,        0);
    chk("arst_dec_channel", dec_channel,   0);
    chk("arst_out_valid",   bus.out_valid, 0);
    chk("arst_busy",        busy,          0);
    chk("arst_drop_err",    drop_err,      0);
    chk("arst_dec_llr",     dec_llr,       0);
    chk("arst_frame_cnt",   frame_cnt,     0);
    bus.llr_valid = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_rst", dec_rst, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_rst",  dec_rst, 0);
    chk("arst_rel_busy", busy,    0);
    exp_llr = '0;
    exp_frames = '0;
    exp_drop = 1'b0;
    run_frame(2, 1, 0, 0);

    force dut.frame_q = 16'hFFFF;
    #1;
    release dut.frame_q;
    exp_frames = 16'hFFFF;
    run_frame(0, 0, 0, 0);
    chk("wrap", frame_cnt, 0);

    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
